instr_prefetch_queue: RTL and testbench

Fetch-side block between the program counter logic and the IF/ID pipeline register. It owns the fetch PC and issues word requests to a variable-latency instruction memory over a req/ack handshake. Returned instructions are buffered in a small FIFO so the decode stage sees a steady stream across memory wait states and hazard stalls. Branch/jump redirects flush the buffer and discard any in-flight fetch.

---
 rtl/pfq_pkg.sv | 14 +
 rtl/pfq_fifo.sv | 67 ++++++
 rtl/instr_prefetch_queue.sv | 132 +++++++++++++
 tb/tb_instr_prefetch_queue.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pfq_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package pfq_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  // One FIFO entry is {fetch address + 4, instruction}.
  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    KILL = 2'd2
  } pfq_state_e;
endpackage

// File: rtl/pfq_fifo.sv
// Circular buffer of DEPTH entries with push/pop/clear and occupancy count.
// DEPTH must be a power of two so the pointers wrap on their own.
module pfq_fifo
  import pfq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] rdata_o,
  output logic [CW-1:0]      count_o,
  output logic               full_o,
  output logic               empty_o
);
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A full buffer can still take a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and count next-state; clear wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until the count covers them.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues one outstanding
// word request at a time and buffers returned instructions for decode.
// Optional macro PREFETCH_BYPASS_EN forwards an ack straight to the outputs
// when the buffer is empty and lets BUSY issue back-to-back requests.
module instr_prefetch_queue
  import pfq_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk_i,
  input  logic               rst_n,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic               if_valid_o,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic [ADDR_W-1:0]  if_pc_plus4_o,
  input  logic               if_ready_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  pfq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] kill_addr_q, kill_addr_d;
  logic [ADDR_W-1:0] redir_pc;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic              busy_ack, byp_hit, byp_take;

  assign redir_pc = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign busy_ack = (state_q == BUSY) & imem_ack_i & ~redirect_i;

`ifdef PREFETCH_BYPASS_EN
  logic [CW-1:0] cnt_nxt;
  assign byp_hit  = busy_ack & fifo_empty;
  assign byp_take = byp_hit & if_ready_i;
  assign cnt_nxt  = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
`else
  assign byp_hit  = 1'b0;
  assign byp_take = 1'b0;
`endif

  // A word consumed through the bypass never enters the buffer.
  assign fifo_push = busy_ack & ~byp_take & (~fifo_full | fifo_pop);
  // Redirect voids any pop: the consumer flushes alongside us.
  assign fifo_pop  = ~fifo_empty & if_ready_i & ~redirect_i;

  pfq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .clr_i   (redirect_i),
    .push_i  (fifo_push),
    .wdata_i ({fetch_pc_q + 32'd4, imem_data_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign imem_req_o  = (state_q != IDLE);
  assign imem_addr_o = (state_q == KILL) ? kill_addr_q : fetch_pc_q;

  // Decode-side outputs: buffer head, else bypassed ack, else zeros.
  always_comb begin
    if_valid_o    = 1'b0;
    if_instr_o    = '0;
    if_pc_plus4_o = '0;
    if (!fifo_empty) begin
      if_valid_o                  = 1'b1;
      {if_pc_plus4_o, if_instr_o} = fifo_rdata;
    end else if (byp_hit) begin
      if_valid_o    = 1'b1;
      if_instr_o    = imem_data_i;
      if_pc_plus4_o = fetch_pc_q + 32'd4;
    end
  end

  // Fetch FSM next-state, fetch PC and kill address.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    kill_addr_d = kill_addr_q;
    unique case (state_q)
      IDLE: begin
        if (fifo_count < DEPTH_C) state_d = BUSY;
        if (redirect_i) fetch_pc_d = redir_pc;
      end
      BUSY: begin
        if (redirect_i) begin
          fetch_pc_d = redir_pc;
          if (imem_ack_i) begin
            state_d = IDLE;
          end else begin
            state_d     = KILL;
            kill_addr_d = fetch_pc_q;
          end
        end else if (imem_ack_i) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = IDLE;
`ifdef PREFETCH_BYPASS_EN
          if (cnt_nxt < DEPTH_C) state_d = BUSY;
`endif
        end
      end
      KILL: begin
        if (redirect_i) fetch_pc_d = redir_pc;
        if (imem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and address registers; reset abandons any in-flight request.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      kill_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      kill_addr_q <= kill_addr_d;
    end
  end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Testbench for instr_prefetch_queue (DEPTH=4). Exact-cycle checks target the
// default build; PREFETCH_BYPASS_EN selects the bypass scenario instead.
module tb_instr_prefetch_queue;
  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_plus4_o;
  logic        if_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  int checks = 0;
  int errors = 0;

  // Memory model knobs: ack after mem_lat waiting cycles, data = addr ^ mem_xor.
  int          mem_lat  = 0;
  int          mem_wait = 0;
  int          ack_cnt  = 0;
  logic [31:0] mem_xor  = 32'h0;

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .if_valid_o(if_valid_o), .if_instr_o(if_instr_o), .if_pc_plus4_o(if_pc_plus4_o),
    .if_ready_i(if_ready_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; the memory model then answers the current request.
  task automatic cyc();
    @(posedge clk_i); #1;
    redirect_i = 1'b0;
    if (imem_req_o && rst_n) begin
      if (mem_wait >= mem_lat) begin
        imem_ack_i = 1'b1; imem_data_i = imem_addr_o ^ mem_xor; mem_wait = 0; ack_cnt++;
      end else begin
        imem_ack_i = 1'b0; imem_data_i = $urandom; mem_wait++;
      end
    end else begin
      imem_ack_i = 1'b0; imem_data_i = $urandom; mem_wait = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; if_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    mem_lat = 0; mem_xor = '0; ack_cnt = 0;
    repeat (3) cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    mem_lat = 5;
    cyc(); #1;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      errors++; $display("FAIL reset_first_req: got req=%b addr=%h exp req=1 addr=0", imem_req_o, imem_addr_o);
    end
    rst_n = 1'b0;            // reset mid-request
    cyc();
    imem_ack_i = 1'b1; imem_data_i = 32'hBAD0_0000;
    #1;
    checks++;
    if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", imem_req_o); end
    checks++;
    if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", imem_addr_o); end
    checks++;
    if (if_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", if_valid_o); end
    checks++;
    if (if_instr_o !== 32'h0 || if_pc_plus4_o !== 32'h0) begin
      errors++; $display("FAIL reset_data: got instr=%h pc4=%h exp 0 0", if_instr_o, if_pc_plus4_o);
    end
    cyc();                   // ack seen while in reset
    rst_n = 1'b1;
    cyc(); #1;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || if_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_ack_ignored: got req=%b addr=%h valid=%b exp 1 0 0", imem_req_o, imem_addr_o, if_valid_o);
    end
  endtask

`ifndef PREFETCH_BYPASS_EN
  // Zero-wait memory, consumer always ready: req on odd cycles, data on even.
  task automatic test_stream();
    logic        e_req, e_val;
    logic [31:0] e_addr, e_ins, e_pc4;
    do_reset();
    if_ready_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc(); #1;
      e_req  = (k % 2 == 1);
      e_addr = 32'(4 * ((k - 1) / 2));
      e_val  = (k % 2 == 0);
      e_ins  = e_val ? 32'(4 * (k / 2 - 1)) : 32'h0;
      e_pc4  = e_val ? e_ins + 32'd4 : 32'h0;
      checks++;
      if (imem_req_o !== e_req || (e_req && imem_addr_o !== e_addr) || if_valid_o !== e_val ||
          if_instr_o !== e_ins || if_pc_plus4_o !== e_pc4) begin
        errors++;
        $display("FAIL stream k=%0d: got req=%b addr=%h v=%b ins=%h pc4=%h exp req=%b addr=%h v=%b ins=%h pc4=%h",
                 k, imem_req_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_plus4_o, e_req, e_addr, e_val, e_ins, e_pc4);
      end
    end
  endtask

  // Ack, pop and redirect together: the acked word must vanish.
  task automatic test_redirect_ack();
    logic got;
    do_reset();
    cyc(); cyc(); cyc(); #1;
    checks++;
    if (!(imem_req_o && imem_ack_i && if_valid_o && imem_addr_o == 32'h4)) begin
      errors++; $display("FAIL redir_ack_setup: got req=%b ack=%b v=%b addr=%h exp 1 1 1 4", imem_req_o, imem_ack_i, if_valid_o, imem_addr_o);
    end
    if_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0202;
    cyc(); #1;
    checks++;
    if (if_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      errors++; $display("FAIL redir_ack_flush: got v=%b req=%b exp 0 0", if_valid_o, imem_req_o);
    end
    cyc(); #1;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
      errors++; $display("FAIL redir_ack_req: got req=%b addr=%h exp 1 200", imem_req_o, imem_addr_o);
    end
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      cyc(); #1;
      if (if_valid_o) begin
        got = 1'b1;
        checks++;
        if (if_instr_o !== 32'h200 || if_pc_plus4_o !== 32'h204) begin
          errors++; $display("FAIL redir_ack_data: got ins=%h pc4=%h exp 200 204", if_instr_o, if_pc_plus4_o);
        end
      end
    end
    if (!got) begin checks++; errors++; $display("FAIL redir_ack_timeout: got no delivery exp 200"); end
  endtask
`else
  // Empty buffer, ready consumer: ack data appears in the ack cycle and is not stored.
  task automatic test_bypass();
    do_reset();
    mem_xor = 32'hDEAD_BEEF; if_ready_i = 1'b1;
    cyc(); #1;
    checks++;
    if (imem_ack_i !== 1'b1 || if_valid_o !== 1'b1 || if_instr_o !== 32'hDEAD_BEEF || if_pc_plus4_o !== 32'h4) begin
      errors++; $display("FAIL bypass_same_cycle: got ack=%b v=%b ins=%h pc4=%h exp 1 1 deadbeef 4", imem_ack_i, if_valid_o, if_instr_o, if_pc_plus4_o);
    end
    mem_lat = 5;
    cyc(); #1;
    checks++;
    if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
      errors++; $display("FAIL bypass_not_stored: got v=%b req=%b addr=%h exp 0 1 4", if_valid_o, imem_req_o, imem_addr_o);
    end
  endtask
`endif

  // Consumer stalled 20 cycles: exactly DEPTH words fetched, then drained in order.
  task automatic test_stall();
    int n;
    do_reset();
    repeat (20) cyc();
    #1;
    checks++;
    if (ack_cnt !== 4 || imem_req_o !== 1'b0 || if_valid_o !== 1'b1 || if_instr_o !== 32'h0) begin
      errors++; $display("FAIL stall_full: got acks=%0d req=%b v=%b ins=%h exp 4 0 1 0", ack_cnt, imem_req_o, if_valid_o, if_instr_o);
    end
    if_ready_i = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      if (if_valid_o) begin
        checks++;
        if (if_instr_o !== 32'(4 * n) || if_pc_plus4_o !== 32'(4 * n + 4)) begin
          errors++; $display("FAIL stall_drain[%0d]: got ins=%h pc4=%h exp %h %h", n, if_instr_o, if_pc_plus4_o, 4 * n, 4 * n + 4);
        end
        n++;
      end
      cyc(); #1;
    end
    if (n < 5) begin checks++; errors++; $display("FAIL stall_timeout: got %0d words exp 5", n); end
  endtask

  // Redirect while BUSY with a slow memory: old address held, its data dropped.
  task automatic test_redirect_kill();
    logic acked, got;
    do_reset();
    mem_lat = 3; if_ready_i = 1'b1;
    cyc(); #1;
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    cyc();
    acked = 1'b0;
    for (int c = 0; c < 10 && !acked; c++) begin
      #1;
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || if_valid_o !== 1'b0) begin
        errors++; $display("FAIL kill_hold: got req=%b addr=%h v=%b exp 1 0 0", imem_req_o, imem_addr_o, if_valid_o);
      end
      if (imem_ack_i) acked = 1'b1;
      else cyc();
    end
    if (!acked) begin checks++; errors++; $display("FAIL kill_timeout: got no ack exp ack"); end
    cyc(); #1;
    checks++;
    if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin
      errors++; $display("FAIL kill_drop: got req=%b v=%b exp 0 0", imem_req_o, if_valid_o);
    end
    cyc(); #1;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
      errors++; $display("FAIL kill_new_req: got req=%b addr=%h exp 1 100", imem_req_o, imem_addr_o);
    end
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      cyc(); #1;
      if (if_valid_o) begin
        got = 1'b1;
        checks++;
        if (if_instr_o !== 32'h100) begin errors++; $display("FAIL kill_first_word: got %h exp 100", if_instr_o); end
      end
    end
    if (!got) begin checks++; errors++; $display("FAIL kill_deliver_timeout: got none exp 100"); end
  endtask

  // Fetch at 0xFFFF_FFFC: pc+4 wraps to 0 and the next request is address 0.
  task automatic test_wrap();
    logic got;
    do_reset();
    cyc(); #1;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      cyc(); #1;
      if (if_valid_o) begin
        got = 1'b1;
        checks++;
        if (if_instr_o !== 32'hFFFF_FFFC || if_pc_plus4_o !== 32'h0) begin
          errors++; $display("FAIL wrap_data: got ins=%h pc4=%h exp fffffffc 0", if_instr_o, if_pc_plus4_o);
        end
      end
    end
    if (!got) begin checks++; errors++; $display("FAIL wrap_timeout: got none exp fffffffc"); end
    if_ready_i = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      cyc(); #1;
      if (imem_req_o) begin
        got = 1'b1;
        checks++;
        if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_next_req: got %h exp 0", imem_addr_o); end
      end
    end
    if (!got) begin checks++; errors++; $display("FAIL wrap_req_timeout: got none exp req"); end
  endtask

  // Random ready/latency/redirects against a stream model: after every redirect
  // the consumer must see target, target+4, ... with data = addr ^ key.
  task automatic test_random();
    logic [31:0] exp_pc, prev_addr;
    logic        prev_req, prev_ack;
    int          delivered;
    do_reset();
    mem_xor = 32'h1234_5678;
    exp_pc = 32'h0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      if_ready_i    = ($urandom_range(0, 99) < 60);
      redirect_i    = ($urandom_range(0, 99) < 4);
      redirect_pc_i = $urandom;
      if (!imem_req_o) mem_lat = $urandom_range(0, 3);
      #1;
      if (prev_req && !prev_ack && imem_req_o) begin
        checks++;
        if (imem_addr_o !== prev_addr) begin
          errors++; $display("FAIL rnd_addr_stable c=%0d: got %h exp %h", c, imem_addr_o, prev_addr);
        end
      end
      if (!if_valid_o) begin
        checks++;
        if (if_instr_o !== 32'h0 || if_pc_plus4_o !== 32'h0) begin
          errors++; $display("FAIL rnd_zero_when_invalid c=%0d: got ins=%h pc4=%h exp 0 0", c, if_instr_o, if_pc_plus4_o);
        end
      end
`ifndef PREFETCH_BYPASS_EN
      if (prev_ack) begin
        checks++;
        if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rnd_idle_gap c=%0d: got req=%b exp 0", c, imem_req_o); end
      end
`endif
      if (if_valid_o && if_ready_i && !redirect_i) begin
        checks++;
        if (if_instr_o !== (exp_pc ^ mem_xor) || if_pc_plus4_o !== exp_pc + 32'd4) begin
          errors++; $display("FAIL rnd_stream c=%0d: got ins=%h pc4=%h exp %h %h", c, if_instr_o, if_pc_plus4_o, exp_pc ^ mem_xor, exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (redirect_i) exp_pc = {redirect_pc_i[31:2], 2'b00};
      prev_req = imem_req_o; prev_ack = imem_ack_i; prev_addr = imem_addr_o;
      cyc();
    end
    checks++;
    if (delivered < 100) begin errors++; $display("FAIL rnd_progress: got %0d words exp >=100", delivered); end
  endtask

  initial begin
    rst_n = 1'b0; imem_ack_i = 1'b0; imem_data_i = '0;
    if_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    test_reset();
`ifndef PREFETCH_BYPASS_EN
    test_stream();
    test_redirect_ack();
`else
    test_bypass();
`endif
    test_stall();
    test_redirect_kill();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
